// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - next-PC select, fetch enables and run/step/halt sequencing
module pc_sequencer #(
  parameter int len       = 32,
  parameter int CNT_W     = 32,
  parameter int DRAIN_CYC = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_mode,
  input  logic             i_step,
  input  logic             i_stall,
  input  logic             i_branch_taken,
  input  logic [len-1:0]   i_branch_target,
  input  logic             i_jump,
  input  logic [len-1:0]   i_jump_target,
  input  logic             i_halt_instr,
  input  logic [len-1:0]   i_pc,
  output logic [len-1:0]   o_next_pc,
  output logic             o_pc_en,
  output logic             o_pipe_en,
  output logic             o_flush,
  output logic [2:0]       o_state,
  output logic             o_halted,
  output logic [CNT_W-1:0] o_cycle_count
);

  localparam int DW = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RUN       = 3'd1,
    STEP_WAIT = 3'd2,
    STEP_EXEC = 3'd3,
    DRAIN     = 3'd4,
    HALTED    = 3'd5
  } state_t;

  state_t        state;
  logic [DW-1:0] drain_cnt;
  logic          exec_state;
  logic          redirect;
  logic          halt_go;

  assign exec_state = (state == RUN) || (state == STEP_EXEC);
  assign redirect   = i_branch_taken | i_jump;
  // A halt under a taken branch is wrong-path; under a stall it is retried next cycle.
  assign halt_go    = exec_state & i_halt_instr & ~i_stall & ~i_branch_taken;
  assign o_state    = state;

  always_comb begin
    o_next_pc = i_pc + len'(4);
    if (i_branch_taken)  o_next_pc = i_branch_target;
    else if (i_jump)     o_next_pc = i_jump_target;
    else if (i_stall)    o_next_pc = i_pc;
  end

  always_comb begin
    o_pc_en   = 1'b0;
    o_pipe_en = 1'b0;
    o_flush   = 1'b0;
    case (state)
      RUN, STEP_EXEC: begin
        o_pipe_en = 1'b1;
        if (halt_go) begin
          o_flush = 1'b1;
        end else begin
          o_pc_en = redirect | ~i_stall;
          o_flush = redirect;
        end
      end
      DRAIN: begin
        o_pipe_en = 1'b1;
        o_flush   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= IDLE;
      drain_cnt     <= '0;
      o_halted      <= 1'b0;
      o_cycle_count <= '0;
    end else begin
      if (o_pipe_en && (o_cycle_count != {CNT_W{1'b1}}))
        o_cycle_count <= o_cycle_count + CNT_W'(1);
      case (state)
        IDLE: begin
          if (i_start) state <= i_mode ? STEP_WAIT : RUN;
        end
        RUN: begin
          if (halt_go) begin
            state     <= DRAIN;
            drain_cnt <= DW'(DRAIN_CYC);
          end
        end
        STEP_WAIT: begin
          if (i_step) state <= STEP_EXEC;
        end
        STEP_EXEC: begin
          if (halt_go) begin
            state     <= DRAIN;
            drain_cnt <= DW'(DRAIN_CYC);
          end else begin
            state <= STEP_WAIT;
          end
        end
        DRAIN: begin
          if (drain_cnt <= DW'(1)) begin
            state     <= HALTED;
            drain_cnt <= '0;
            o_halted  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - DW'(1);
          end
        end
        HALTED: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
